// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the triadic register/ALU datapath.
// Every output is a register loaded on the tick edge that enters its state; tick=0 freezes everything.
module control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [31:0]      IR,
  input  logic             RS1is0,
  output logic             IRLoad,
  output logic             PCWrite,
  output logic             NextPC,
  output logic             WE,
  output logic             DinSel2,
  output logic             Oprnd1Sel,
  output logic             Oprnd2Sel,
  output logic             ExtnCntl,
  output logic             RDSEL,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;
  typedef enum logic [2:0] {C_R, C_IALU, C_J, C_JAL, C_BEQZ, C_HALT, C_ILL} cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, cls_dec;
  logic [5:0]        op;
  logic              unused_ir;
  logic              ir_load_q, ir_load_d;
  logic              pc_write_q, pc_write_d;
  logic              next_pc_q, next_pc_d;
  logic              we_q, we_d;
  logic              din_sel2_q, din_sel2_d;
  logic              oprnd1_sel_q, oprnd1_sel_d;
  logic              oprnd2_sel_q, oprnd2_sel_d;
  logic              extn_cntl_q, extn_cntl_d;
  logic              rdsel_q, rdsel_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  assign op        = IR[31:26];
  assign unused_ir = ^IR[25:0];

  always_comb begin
    cls_dec = C_ILL;
    if (op == 6'b000000)       cls_dec = C_R;
    else if (op[5:3] == 3'b001) cls_dec = C_IALU;
    else if (op == 6'b000010)  cls_dec = C_J;
    else if (op == 6'b000011)  cls_dec = C_JAL;
    else if (op == 6'b000100)  cls_dec = C_BEQZ;
    else if (op == 6'b111111)  cls_dec = C_HALT;
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    ir_load_d    = ir_load_q;
    pc_write_d   = pc_write_q;
    next_pc_d    = next_pc_q;
    we_d         = we_q;
    din_sel2_d   = din_sel2_q;
    oprnd1_sel_d = oprnd1_sel_q;
    oprnd2_sel_d = oprnd2_sel_q;
    extn_cntl_d  = extn_cntl_q;
    rdsel_d      = rdsel_q;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    retired_d    = retired_q;

    if (tick) begin
      // Strobes last exactly one tick interval; each state re-asserts what it needs.
      ir_load_d  = 1'b0;
      pc_write_d = 1'b0;
      next_pc_d  = 1'b0;
      we_d       = 1'b0;
      din_sel2_d = 1'b0;
      if (pc_write_q) retired_d = retired_q + CNT_W'(1);

      case (state_q)
        S_FETCH: begin
          state_d      = S_DECODE;
          cls_d        = cls_dec;
          oprnd1_sel_d = (cls_dec == C_J) || (cls_dec == C_JAL) || (cls_dec == C_BEQZ);
          oprnd2_sel_d = (cls_dec == C_IALU) || (cls_dec == C_J) || (cls_dec == C_JAL) ||
                         (cls_dec == C_BEQZ);
          extn_cntl_d  = (cls_dec == C_J) || (cls_dec == C_JAL);
          rdsel_d      = (cls_dec == C_R);
        end
        S_DECODE: begin
          if (cls_q == C_HALT || cls_q == C_ILL) begin
            state_d   = S_HALTED;
            halted_d  = 1'b1;
            illegal_d = (cls_q == C_ILL);
          end else begin
            state_d = S_EXEC;
            if (cls_q == C_J || cls_q == C_BEQZ) begin
              pc_write_d = 1'b1;
              next_pc_d  = (cls_q == C_J) ? 1'b1 : RS1is0;
            end
          end
        end
        S_EXEC: begin
          if (cls_q == C_J || cls_q == C_BEQZ) begin
            state_d   = S_FETCH;
            ir_load_d = 1'b1;
          end else begin
            state_d    = S_WB;
            we_d       = 1'b1;
            pc_write_d = 1'b1;
            din_sel2_d = (cls_q != C_JAL);
            next_pc_d  = (cls_q == C_JAL);
          end
        end
        S_WB: begin
          state_d   = S_FETCH;
          ir_load_d = 1'b1;
        end
        default: state_d = S_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      cls_q        <= C_R;
      ir_load_q    <= 1'b1;
      pc_write_q   <= 1'b0;
      next_pc_q    <= 1'b0;
      we_q         <= 1'b0;
      din_sel2_q   <= 1'b0;
      oprnd1_sel_q <= 1'b0;
      oprnd2_sel_q <= 1'b0;
      extn_cntl_q  <= 1'b0;
      rdsel_q      <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      ir_load_q    <= ir_load_d;
      pc_write_q   <= pc_write_d;
      next_pc_q    <= next_pc_d;
      we_q         <= we_d;
      din_sel2_q   <= din_sel2_d;
      oprnd1_sel_q <= oprnd1_sel_d;
      oprnd2_sel_q <= oprnd2_sel_d;
      extn_cntl_q  <= extn_cntl_d;
      rdsel_q      <= rdsel_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      retired_q    <= retired_d;
    end
  end

  assign IRLoad    = ir_load_q;
  assign PCWrite   = pc_write_q;
  assign NextPC    = next_pc_q;
  assign WE        = we_q;
  assign DinSel2   = din_sel2_q;
  assign Oprnd1Sel = oprnd1_sel_q;
  assign Oprnd2Sel = oprnd2_sel_q;
  assign ExtnCntl  = extn_cntl_q;
  assign RDSEL     = rdsel_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized bench for control_unit; expectations come from a per-tick table model of each
// instruction class, with outputs sampled on the falling clock edge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst, tick, rs1is0;
  logic [31:0] ir;
  logic        ir_load, pc_write, next_pc, we, din_sel2, o1, o2, extn, rdsel, halted, illegal;
  logic [31:0] retired;
  logic [6:0]  strb;
  logic [3:0]  sels;
  logic [42:0] snap_now;

  int vectors     = 0;
  int miscompares = 0;
  int exp_retired = 0;

  localparam logic [42:0] RESET_VEC = {7'b1000000, 4'b0000, 32'd0};

  control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .tick(tick), .IR(ir), .RS1is0(rs1is0),
    .IRLoad(ir_load), .PCWrite(pc_write), .NextPC(next_pc), .WE(we), .DinSel2(din_sel2),
    .Oprnd1Sel(o1), .Oprnd2Sel(o2), .ExtnCntl(extn), .RDSEL(rdsel),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign strb     = {ir_load, pc_write, next_pc, we, din_sel2, halted, illegal};
  assign sels     = {o1, o2, extn, rdsel};
  assign snap_now = {strb, sels, retired};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op >= 6'd8 && op <= 6'd15) || (op == 6'd2) || (op == 6'd3) ||
           (op == 6'd4) || (op == 6'd63);
  endfunction

  // Idle for gap clocks (outputs must stay frozen), then one tick edge; returns RS1is0 at that edge.
  task automatic step(input int gap, input int rs_mode, output bit rs_at);
    logic [42:0] snap;
    snap = snap_now;
    repeat (gap) begin
      rs1is0 = 1'($urandom);
      @(negedge clk);
      chk("freeze", 64'(snap_now), 64'(snap));
    end
    rs1is0 = (rs_mode == 2) ? 1'($urandom) : 1'(rs_mode);
    rs_at  = rs1is0;
    tick   = 1'b1;
    @(negedge clk);
    tick   = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tick = 1'($urandom);
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    exp_retired = 0;
    chk("reset_state", 64'(snap_now), 64'(RESET_VEC));
  endtask

  // Runs one instruction from FETCH; halting classes get three extra ticks in HALTED.
  task automatic run_instr(input logic [31:0] word, input int gap, input int rs_mode);
    logic [5:0] op;
    bit is_r, is_i, is_j, is_jal, is_beqz, is_halt, is_ill, stops, rs_at, rs_exec;
    int len;
    logic [3:0] esel;
    logic [6:0] es;
    op      = word[31:26];
    is_r    = (op == 6'd0);
    is_i    = (op >= 6'd8 && op <= 6'd15);
    is_j    = (op == 6'd2);
    is_jal  = (op == 6'd3);
    is_beqz = (op == 6'd4);
    is_halt = (op == 6'd63);
    is_ill  = !is_legal(op);
    stops   = is_halt || is_ill;
    len     = stops ? 2 : (is_j || is_beqz) ? 3 : 4;
    esel    = is_r ? 4'b0001 : is_i ? 4'b0100 : (is_j || is_jal) ? 4'b1110 :
              is_beqz ? 4'b1100 : 4'b0000;
    ir      = word;
    rs_exec = 1'b0;
    for (int t = 1; t <= len + (stops ? 3 : 0); t++) begin
      step(gap, rs_mode, rs_at);
      if (t == 2) rs_exec = rs_at;
      es = 7'b0;
      if (stops) begin
        if (t >= 2) es = {5'b0, 1'b1, is_ill};
      end else if (t == len) es = 7'b1000000;
      else if (t == 2 && (is_j || is_beqz)) es = {1'b0, 1'b1, (is_j ? 1'b1 : rs_exec), 4'b0};
      else if (t == 3) es = {1'b0, 1'b1, is_jal, 1'b1, !is_jal, 2'b0};
      if (!stops && t == len) exp_retired++;
      chk($sformatf("strobes op=%02h t=%0d", op, t), 64'(strb), 64'(es));
      if (!stops && t < len) chk($sformatf("selects op=%02h t=%0d", op, t), 64'(sels), 64'(esel));
      chk($sformatf("retired op=%02h t=%0d", op, t), 64'(retired), 64'(exp_retired));
    end
  endtask

  initial begin
    bit          rs;
    int          k;
    logic [5:0]  op;
    rst = 1'b1; tick = 1'b0; rs1is0 = 1'b0; ir = 32'd0;
    @(negedge clk);
    do_reset();

    run_instr(32'h00221820, 3, 2);
    run_instr({6'b001000, 26'($urandom)}, 3, 2);
    run_instr({6'b000100, 26'($urandom)}, 1, 1);
    run_instr({6'b000100, 26'($urandom)}, 1, 0);
    run_instr({6'b000011, 26'($urandom)}, 2, 2);
    run_instr({6'b000010, 26'($urandom)}, 0, 2);
    run_instr({6'b111111, 26'($urandom)}, 1, 2);
    do_reset();
    run_instr({6'b010101, 26'($urandom)}, 1, 2);
    do_reset();

    // Reset lands on the edge that would enter WB: the write must never appear.
    run_instr(32'h00221820, 0, 2);
    ir = 32'h00221820;
    step(0, 2, rs);
    step(0, 2, rs);
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    exp_retired = 0;
    chk("reset_mid_instr", 64'(snap_now), 64'(RESET_VEC));
    repeat (10) begin
      @(negedge clk);
      chk("we_after_reset", 64'(we), 64'(0));
      chk("frozen_after_reset", 64'(snap_now), 64'(RESET_VEC));
    end

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 19);
      if (k < 5)       op = 6'd0;
      else if (k < 9)  op = {3'b001, 3'($urandom)};
      else if (k < 11) op = 6'd2;
      else if (k < 14) op = 6'd3;
      else if (k < 18) op = 6'd4;
      else if (k < 19) op = 6'd63;
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr({op, 26'($urandom)}, $urandom_range(0, 3), 2);
      if (k >= 18) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
